// File: rtl/sxtf_bit_adder.sv
// 64-bit a + b + cin adder: 4-bit lookahead groups, 16-bit blocks, top lookahead unit.
// Latency: 1 cycle, registered sum/ca; throughput 1 operation per cycle.
// Backpressure: none; inputs are sampled on every rising clk edge.
module sxtf_bit_adder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        cin,
    output logic [63:0] sum,
    output logic        ca
);

    // Four-way lookahead: group generate, independent of the carry-in.
    function automatic logic lah_gen(input logic [3:0] g, input logic [3:0] p);
        return g[3]
             | (p[3] & g[2])
             | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);
    endfunction

    // Four-way lookahead: group propagate.
    function automatic logic lah_prop(input logic [3:0] p);
        return p[3] & p[2] & p[1] & p[0];
    endfunction

    // Four-way lookahead: carries into positions 0..3, all derived directly from ci.
    function automatic logic [3:0] lah_carry(input logic [3:0] g,
                                             input logic [3:0] p,
                                             input logic       ci);
        logic [3:0] c;
        c[0] = ci;
        c[1] = g[0]
             | (p[0] & ci);
        c[2] = g[1]
             | (p[1] & g[0])
             | (p[1] & p[0] & ci);
        c[3] = g[2]
             | (p[2] & g[1])
             | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & ci);
        return c;
    endfunction

    logic [63:0] bit_g;
    logic [63:0] bit_p;
    logic [63:0] bit_c;

    logic [15:0] grp_g;
    logic [15:0] grp_p;
    logic [15:0] grp_ci;

    logic [3:0]  blk_g;
    logic [3:0]  blk_p;
    logic [3:0]  blk_ci;

    logic        top_g;
    logic        top_p;
    logic [63:0] sum_next;
    logic        ca_next;

    assign bit_g = a & b;
    assign bit_p = a ^ b;

    // Level 1: group G/P from bit G/P; group internal carries once the group carry-in is known.
    for (genvar k = 0; k < 16; k++) begin : g_grp
        assign grp_g[k] = lah_gen(bit_g[4*k +: 4], bit_p[4*k +: 4]);
        assign grp_p[k] = lah_prop(bit_p[4*k +: 4]);
        assign bit_c[4*k +: 4] = lah_carry(bit_g[4*k +: 4], bit_p[4*k +: 4], grp_ci[k]);
    end

    // Level 2: each block folds its four groups into block G/P and distributes group carry-ins.
    for (genvar m = 0; m < 4; m++) begin : g_blk
        assign blk_g[m] = lah_gen(grp_g[4*m +: 4], grp_p[4*m +: 4]);
        assign blk_p[m] = lah_prop(grp_p[4*m +: 4]);
        assign grp_ci[4*m +: 4] = lah_carry(grp_g[4*m +: 4], grp_p[4*m +: 4], blk_ci[m]);
    end

    // Top unit: block carry-ins c[0], c[16], c[32], c[48] and the final carry c[64].
    assign blk_ci   = lah_carry(blk_g, blk_p, cin);
    assign top_g    = lah_gen(blk_g, blk_p);
    assign top_p    = lah_prop(blk_p);
    assign ca_next  = top_g | (top_p & cin);
    assign sum_next = bit_p ^ bit_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= '0;
            ca  <= 1'b0;
        end else begin
            sum <= sum_next;
            ca  <= ca_next;
        end
    end

endmodule

// File: tb/tb_sxtf_bit_adder.sv
// Randomized scoreboard bench for sxtf_bit_adder against a 65-bit arithmetic reference.
module tb_sxtf_bit_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic [63:0] sum;
    logic        ca;

    logic [64:0] exp_q[$];
    logic [64:0] mon_exp;
    bit          mon_en;
    int          n_chk;
    int          n_fail;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    sxtf_bit_adder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sum   (sum),
        .ca    (ca)
    );

    always #5 clk = ~clk;

    function automatic logic [64:0] ref_add(input logic [63:0] x, input logic [63:0] y,
                                            input logic c);
        logic [64:0] r;
        r = {1'b0, x} + {1'b0, y} + {64'd0, c};
        return r;
    endfunction

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got ca=%0b sum=%h, expected ca=%0b sum=%h",
                     name, act[64], act[63:0], req[64], req[63:0]);
        end
    endtask

    // Inputs change at negedge; the result is expected after the following posedge.
    task automatic drive(input logic [63:0] x, input logic [63:0] y, input logic c);
        @(negedge clk);
        a   = x;
        b   = y;
        cin = c;
        exp_q.push_back(ref_add(x, y, c));
    endtask

    always @(posedge clk) begin
        #2;
        if (mon_en && exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            check("result", {ca, sum}, mon_exp);
        end
    end

    initial begin
        n_chk  = 0;
        n_fail = 0;
        mon_en = 1'b0;
        rst_n  = 1'b1;
        a      = '0;
        b      = '0;
        cin    = 1'b0;

        #2 rst_n = 1'b0;
        #1 check("reset_async", {ca, sum}, 65'd0);
        a   = 64'h1234_5678_9ABC_DEF0;
        b   = 64'h1111_1111_1111_1111;
        cin = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("reset_hold", {ca, sum}, 65'd0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        drive(64'd0, 64'd0, 1'b1);
        drive(64'd1, 64'd16, 1'b0);
        drive(64'd500, 64'd3, 1'b0);
        drive(ONES, 64'd0, 1'b1);
        drive(64'h0000_0000_0000_FFFF, 64'd1, 1'b0);
        drive(64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0);
        drive(64'h0000_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        drive(64'h0000_0000_0000_FFFF, 64'd0, 1'b1);
        drive(ONES, ONES, 1'b1);
        drive(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
        drive(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1);
        drive(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b0);
        drive(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b1);
        drive(64'd0, 64'd0, 1'b0);
        repeat (2) @(posedge clk);

        // Nonzero result on the outputs, then an in-flight operation killed by reset.
        drive(64'hDEAD_BEEF_0000_0001, 64'h0000_0000_1111_0002, 1'b1);
        @(negedge clk);
        mon_en = 1'b0;
        a   = 64'h0F0F_0F0F_0F0F_0F0F;
        b   = 64'h0101_0101_0101_0101;
        cin = 1'b0;
        #2 rst_n = 1'b0;
        #1 check("reset_midstream", {ca, sum}, 65'd0);
        exp_q.delete();
        @(posedge clk);
        #1 check("reset_over_edge", {ca, sum}, 65'd0);
        a   = 64'd5;
        b   = 64'd7;
        cin = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        check("release_no_capture", {ca, sum}, 65'd0);
        @(posedge clk);
        #1 check("first_after_release", {ca, sum}, 65'd12);
        mon_en = 1'b1;

        for (int i = 0; i < 20000; i++) begin
            logic [63:0] x;
            logic [63:0] y;
            x = {$urandom, $urandom};
            y = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0: y = ~x;
                1: x = ONES;
                2: y = 64'd0;
                default: ;
            endcase
            drive(x, y, 1'($urandom_range(0, 1)));
        end
        repeat (3) @(posedge clk);

        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d results never observed, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
